mul_arbiter: RTL and testbench

- Sequencer and two-requester arbiter in front of the shared 8x8 Booth radix-2 multiplier.
- Accepts multiply requests from two clients and picks one round-robin.
- Drives the multiplier's start/operand inputs and waits for its stop.
- Captures the registered 16-bit product and returns it to the granted client with a one-cycle done pulse.

---
 rtl/mul_arbiter_pkg.sv | 25 ++
 rtl/mul_arbiter_rr_arb2.sv | 20 ++
 rtl/mul_arbiter.sv | 135 +++++++++++++
 tb/tb_mul_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_arbiter_pkg.sv
// rtl/mul_arbiter_pkg.sv - shared state codes, defaults and state decode helpers for mul_arbiter
package mul_arbiter_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TIMEOUT = 64;

  typedef logic [2:0] state_t;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] BUSY = 3'd2;
  localparam logic [2:0] CAPT = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  // The granted client owns the multiplier from LOAD through DONE.
  function automatic logic owns_bus(input state_t s);
    return (s == LOAD) || (s == BUSY) || (s == CAPT) || (s == DONE);
  endfunction

  // Operands are presented to the multiplier from LOAD through CAPT.
  function automatic logic drives_ops(input state_t s);
    return (s == LOAD) || (s == BUSY) || (s == CAPT);
  endfunction

endpackage

// File: rtl/mul_arbiter_rr_arb2.sv
// rtl/mul_arbiter_rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic pick,
  output logic valid
);

  // Lone requester wins; on contention the client that did not go last wins.
  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      pick = ~last;
    end else begin
      pick = req1;
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - two-client round-robin sequencer for a shared multiplier (optional watchdog: MUL_ARB_WDOG_EN)
module mul_arbiter
  import mul_arbiter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               done0,
  output logic               done1,
  output logic [2*WIDTH-1:0] res,
  output logic               err,
  output logic               mul_bgn,
  output logic [WIDTH-1:0]   mul_ibusa,
  output logic [WIDTH-1:0]   mul_ibusb,
  output logic               mul_rst_b,
  input  logic               mul_stop,
  input  logic [2*WIDTH-1:0] mul_obus
);

  state_t           state;
  logic             owner;
  logic             last;
  logic             stop_low;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             pick;
  logic             pick_valid;

`ifdef MUL_ARB_WDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wd_cnt;
  logic             abort_q;
`endif

  rr_arb2 u_rr (
    .req0  (req0),
    .req1  (req1),
    .last  (last),
    .pick  (pick),
    .valid (pick_valid)
  );

  // Job sequencing: grant, launch, wait for a fresh stop, capture, report.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      stop_low <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      res      <= '0;
`ifdef MUL_ARB_WDOG_EN
      wd_cnt   <= '0;
      abort_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner <= pick;
            op_a  <= pick ? a1 : a0;
            op_b  <= pick ? b1 : b0;
            state <= LOAD;
          end
        end
        LOAD: begin
          stop_low <= 1'b0;
`ifdef MUL_ARB_WDOG_EN
          wd_cnt   <= '0;
`endif
          state    <= BUSY;
        end
        BUSY: begin
          // A stop still high from the previous job only counts after it has dropped once.
          if (!mul_stop) begin
            stop_low <= 1'b1;
          end
          if (mul_stop && stop_low) begin
            state <= CAPT;
          end
`ifdef MUL_ARB_WDOG_EN
          else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
            res     <= '0;
            abort_q <= 1'b1;
            state   <= DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        CAPT: begin
          // The multiplier registers its product one cycle after stop.
          res   <= mul_obus;
          state <= DONE;
        end
        DONE: begin
          last  <= owner;
`ifdef MUL_ARB_WDOG_EN
          abort_q <= 1'b0;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign gnt0      = owns_bus(state) & ~owner;
  assign gnt1      = owns_bus(state) & owner;
  assign done0     = (state == DONE) & ~owner;
  assign done1     = (state == DONE) & owner;
  assign mul_bgn   = (state == LOAD);
  assign mul_ibusa = drives_ops(state) ? op_a : '0;
  assign mul_ibusb = drives_ops(state) ? op_b : '0;

`ifdef MUL_ARB_WDOG_EN
  assign err       = (state == DONE) & abort_q;
  assign mul_rst_b = ~rst & ~((state == DONE) & abort_q);
`else
  assign err       = 1'b0;
  assign mul_rst_b = ~rst;
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// tb/tb_mul_arbiter.sv - directed scoreboard bench for mul_arbiter with a multiplier model
module tb_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [7:0]  a0, b0, a1, b1;
  logic        gnt0, gnt1, done0, done1, err;
  logic [15:0] res;
  logic        mul_bgn, mul_rst_b;
  logic [7:0]  mul_ibusa, mul_ibusb;
  logic        mul_stop;
  logic [15:0] mul_obus;

  typedef struct packed {
    logic        who;
    logic [15:0] res;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int bgn_cnt = 0;
  int rstb_low_cnt = 0;

  // multiplier model controls
  bit        bfm_hold = 1'b0;
  bit        bfm_never = 1'b0;
  bit        bfm_run, bfm_fire;
  int        bfm_cnt;
  logic [7:0] bfm_a, bfm_b;

  mul_arbiter #(.WIDTH(8), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .a0        (a0),
    .b0        (b0),
    .req1      (req1),
    .a1        (a1),
    .b1        (b1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .done0     (done0),
    .done1     (done1),
    .res       (res),
    .err       (err),
    .mul_bgn   (mul_bgn),
    .mul_ibusa (mul_ibusa),
    .mul_ibusb (mul_ibusb),
    .mul_rst_b (mul_rst_b),
    .mul_stop  (mul_stop),
    .mul_obus  (mul_obus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] prod(input logic [7:0] x, input logic [7:0] y);
    logic signed [15:0] r;
    r = $signed(x) * $signed(y);
    return r;
  endfunction

  // Multiplier model: stop low for a few cycles after bgn, then stop high, product one cycle later.
  always @(posedge clk) begin
    if (!mul_rst_b) begin
      bfm_run  <= 1'b0;
      bfm_fire <= 1'b0;
      bfm_cnt  <= 0;
      mul_stop <= 1'b0;
      mul_obus <= 16'h0;
    end else begin
      if (bfm_fire) begin
        mul_obus <= prod(bfm_a, bfm_b);
        bfm_fire <= 1'b0;
        if (!bfm_hold) mul_stop <= 1'b0;
      end
      if (mul_bgn) begin
        bfm_run <= 1'b1;
        bfm_a   <= mul_ibusa;
        bfm_b   <= mul_ibusb;
        bfm_cnt <= bfm_hold ? 4 : 3;
        if (!bfm_hold) mul_stop <= 1'b0;
      end else if (bfm_run && !bfm_never) begin
        if (bfm_cnt == 4) mul_stop <= 1'b0;
        if (bfm_cnt == 1) begin
          mul_stop <= 1'b1;
          bfm_fire <= 1'b1;
          bfm_run  <= 1'b0;
        end
        bfm_cnt <= bfm_cnt - 1;
      end
    end
  end

  // Output monitor: pops the scoreboard on each done pulse and watches exclusivity.
  always @(negedge clk) begin
    if (!rst) begin
      if (mul_bgn) bgn_cnt++;
      if (!mul_rst_b) rstb_low_cnt++;
      if (gnt0 || gnt1) begin
        n_vec++;
        assert (!(gnt0 && gnt1)) else begin
          n_err++;
          $error("FAIL gnt_excl: gnt0=%0b gnt1=%0b expected not both", gnt0, gnt1);
        end
      end
      if (done0 || done1) begin
        done_cnt++;
        n_vec++;
        assert (!(done0 && done1)) else begin
          n_err++;
          $error("FAIL done_excl: done0=%0b done1=%0b expected not both", done0, done1);
        end
        n_vec++;
        assert (gnt0 === done0 && gnt1 === done1) else begin
          n_err++;
          $error("FAIL gnt_at_done: gnt=%0b%0b expected %0b%0b", gnt1, gnt0, done1, done0);
        end
        n_vec++;
        assert (sb.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_done: done1=%0b res=%0h expected no done", done1, res);
        end
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          n_vec++;
          assert (done1 === mon_e.who) else begin
            n_err++;
            $error("FAIL done_client: got %0d expected %0d", done1, mon_e.who);
          end
          n_vec++;
          assert (res === mon_e.res) else begin
            n_err++;
            $error("FAIL res: got %04h expected %04h", res, mon_e.res);
          end
          n_vec++;
          assert (err === mon_e.err) else begin
            n_err++;
            $error("FAIL err: got %0b expected %0b", err, mon_e.err);
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_dones(input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) begin
      @(negedge clk);
      #1;
    end
    chk("done_timeout", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int b_start, d_start, rl_start;
    logic [7:0] sa [3];
    logic [7:0] sbv [3];

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = 8'h0; b0 = 8'h0; a1 = 8'h0; b1 = 8'h0;
    step(2);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_done0", done0, 0);
    chk("rst_done1", done1, 0);
    chk("rst_err", err, 0);
    chk("rst_bgn", mul_bgn, 0);
    chk("rst_res", res, 0);
    chk("rst_ibusa", mul_ibusa, 0);
    chk("rst_ibusb", mul_ibusb, 0);
    chk("rst_mul_rst_b", mul_rst_b, 0);
    rst = 1'b0;
    step(1);
    chk("run_mul_rst_b", mul_rst_b, 1);

    // contention: client 0 wins first after reset
    a0 = 8'd7; b0 = 8'd6; a1 = 8'h80; b1 = 8'h80;
    sb.push_back('{1'b0, 16'h002A, 1'b0});
    sb.push_back('{1'b1, 16'h4000, 1'b0});
    req0 = 1'b1; req1 = 1'b1;
    wait_dones(done_cnt + 1, 100);
    req0 = 1'b0;
    wait_dones(done_cnt + 1, 100);
    req1 = 1'b0;
    step(2);

    // fairness: both held for four jobs
    a0 = 8'd11; b0 = 8'hF0; a1 = 8'h85; b1 = 8'd3;
    sb.push_back('{1'b0, prod(8'd11, 8'hF0), 1'b0});
    sb.push_back('{1'b1, prod(8'h85, 8'd3), 1'b0});
    sb.push_back('{1'b0, prod(8'd11, 8'hF0), 1'b0});
    sb.push_back('{1'b1, prod(8'h85, 8'd3), 1'b0});
    req0 = 1'b1; req1 = 1'b1;
    wait_dones(done_cnt + 4, 200);
    req0 = 1'b0; req1 = 1'b0;
    chk("fair_sb_empty", sb.size(), 0);
    step(2);

    // single job; operand change after grant must not matter
    a0 = 8'd5; b0 = 8'hFD;
    sb.push_back('{1'b0, 16'hFFF1, 1'b0});
    b_start = bgn_cnt;
    req0 = 1'b1;
    step(2);
    a0 = 8'd99;
    wait_dones(done_cnt + 1, 100);
    req0 = 1'b0;
    chk("single_bgn_pulses", bgn_cnt - b_start, 1);
    step(2);

    // stale stop: model holds stop high between back-to-back client 1 jobs
    sa[0] = 8'd3;   sbv[0] = 8'd4;
    sa[1] = 8'hFE;  sbv[1] = 8'd9;
    sa[2] = 8'd127; sbv[2] = 8'hFF;
    bfm_hold = 1'b1;
    a1 = sa[0]; b1 = sbv[0];
    sb.push_back('{1'b1, prod(sa[0], sbv[0]), 1'b0});
    req1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_dones(done_cnt + 1, 100);
      if (k < 2) begin
        a1 = sa[k+1]; b1 = sbv[k+1];
        sb.push_back('{1'b1, prod(sa[k+1], sbv[k+1]), 1'b0});
        if (k == 0) begin
          step(1);
          chk("regrant_idle_gnt1", gnt1, 0);
          step(1);
          chk("regrant_load_gnt1", gnt1, 1);
          chk("regrant_load_bgn", mul_bgn, 1);
        end
      end else begin
        req1 = 1'b0;
      end
    end
    bfm_hold = 1'b0;
    step(2);

    // reset in the middle of BUSY
    bfm_never = 1'b1;
    a1 = 8'd10; b1 = 8'd10;
    b_start = bgn_cnt;
    req1 = 1'b1;
    for (int i = 0; i < 50 && bgn_cnt == b_start; i++) step(1);
    chk("midrst_bgn_seen", 32'(bgn_cnt > b_start), 1);
    step(3);
    rst = 1'b1;
    #1;
    chk("midrst_gnt1", gnt1, 0);
    chk("midrst_done1", done1, 0);
    chk("midrst_ibusa", mul_ibusa, 0);
    chk("midrst_bgn", mul_bgn, 0);
    chk("midrst_mul_rst_b", mul_rst_b, 0);
    req1 = 1'b0;
    bfm_never = 1'b0;
    step(2);
    rst = 1'b0;
    d_start = done_cnt;
    step(6);
    chk("midrst_no_done", done_cnt - d_start, 0);
    a0 = 8'hF9; b0 = 8'hF9;
    sb.push_back('{1'b0, 16'h0031, 1'b0});
    req0 = 1'b1;
    wait_dones(done_cnt + 1, 100);
    req0 = 1'b0;
    step(2);

`ifdef MUL_ARB_WDOG_EN
    // watchdog: model never stops
    bfm_never = 1'b1;
    rl_start = rstb_low_cnt;
    a0 = 8'd3; b0 = 8'd3;
    sb.push_back('{1'b0, 16'h0000, 1'b1});
    req0 = 1'b1;
    wait_dones(done_cnt + 1, 100);
    req0 = 1'b0;
    step(1);
    chk("wdog_rstb_low_cycles", rstb_low_cnt - rl_start, 1);
    bfm_never = 1'b0;
    step(2);
`else
    rl_start = rstb_low_cnt;
    step(1);
    chk("no_wdog_rstb_low", rstb_low_cnt - rl_start, 0);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
